// File: rtl/regfile_bank_if.sv
// Bus-side port bundle for regfile_bank: select/write/address request plus
// registered read response and the live register image.
interface regfile_bank_if #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
);
   logic                  sel;
   logic                  wr;
   logic [AW-1:0]         addr;
   logic [DW-1:0]         wdata;
   logic [DW/8-1:0]       wstrb;
   logic [DW-1:0]         rdata;
   logic                  rvalid;
   logic                  err;
   logic [DW*DEPTH-1:0]   mem_flat;

   modport master (
      output sel, wr, addr, wdata, wstrb,
      input  rdata, rvalid, err, mem_flat
   );

   modport slave (
      input  sel, wr, addr, wdata, wstrb,
      output rdata, rvalid, err, mem_flat
   );
endinterface

// File: rtl/regfile_bank.sv
// Parametrised control/status register bank with byte-strobed writes,
// registered reads, per-entry clear-on-read and out-of-range error pulses.
module regfile_bank #(
   parameter int               DW       = 16,
   parameter int               DEPTH    = 4,
   parameter int               AW       = $clog2(DEPTH),
   parameter logic [DW-1:0]    RST_VAL  = '0,
   parameter logic [DEPTH-1:0] COR_MASK = '0
) (
   input logic           clk,
   input logic           rst,
   regfile_bank_if.slave bus
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;
   logic          rvalid_q;
   logic          err_q;
   logic          in_range;

   // Only reachable as false when DEPTH is not a power of two.
   assign in_range = (32'(bus.addr) < DEPTH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RST_VAL;
         end
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         if (bus.sel) begin
            if (!in_range) begin
               err_q <= 1'b1;
               if (!bus.wr) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= '0;
               end
            end else if (bus.wr) begin
               for (int k = 0; k < DW/8; k++) begin
                  if (bus.wstrb[k]) begin
                     mem[bus.addr][8*k +: 8] <= bus.wdata[8*k +: 8];
                  end
               end
            end else begin
               rvalid_q <= 1'b1;
               rdata_q  <= mem[bus.addr];
               // Response carries the pre-clear value; the clear lands on the same edge.
               if (COR_MASK[bus.addr]) begin
                  mem[bus.addr] <= '0;
               end
            end
         end
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign bus.mem_flat[DW*g +: DW] = mem[g];
   end

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed vector tables on two 16-bit
// instances plus a randomised run on a 32-bit instance against a reference model.
module tb_regfile_bank;

   typedef struct packed {
      logic        rst;
      logic        sel;
      logic        wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } vec_t;

   typedef struct packed {
      logic        rv;
      logic        er;
      logic [31:0] rd;
   } exp_t;

   typedef struct packed {
      vec_t v;
      exp_t e;
   } row_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] mdl [3][8];
   logic [31:0] rd_last [3];
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   always #5 clk = ~clk;

   regfile_bank_if #(.DW(16), .DEPTH(4)) if_a ();
   regfile_bank_if #(.DW(16), .DEPTH(5)) if_b ();
   regfile_bank_if #(.DW(32), .DEPTH(8)) if_c ();

   regfile_bank #(.DW(16), .DEPTH(4), .RST_VAL(16'hA5A5), .COR_MASK(4'b1000))
      dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
   regfile_bank #(.DW(16), .DEPTH(5), .RST_VAL(16'hA5A5), .COR_MASK(5'b00000))
      dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
   regfile_bank #(.DW(32), .DEPTH(8), .RST_VAL(32'h0), .COR_MASK(8'h24))
      dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

   function automatic int dwf(int id);
      return (id == 2) ? 32 : 16;
   endfunction

   function automatic int depthf(int id);
      case (id)
         0:       return 4;
         1:       return 5;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] rstvf(int id);
      return (id == 2) ? 32'h0 : 32'h0000_A5A5;
   endfunction

   function automatic logic [7:0] corf(int id);
      case (id)
         0:       return 8'h08;
         1:       return 8'h00;
         default: return 8'h24;
      endcase
   endfunction

   // Reference model: advances state for one clock and returns the expected response.
   function automatic exp_t mstep(int id, vec_t v);
      exp_t       e;
      logic [7:0] cm;
      cm   = corf(id);
      e.rv = 1'b0;
      e.er = 1'b0;
      e.rd = rd_last[id];
      if (!v.rst) begin
         for (int i = 0; i < 8; i++) mdl[id][i] = rstvf(id);
         e.rd = '0;
      end else if (v.sel) begin
         if (int'(v.addr) >= depthf(id)) begin
            e.er = 1'b1;
            if (!v.wr) begin
               e.rv = 1'b1;
               e.rd = '0;
            end
         end else if (v.wr) begin
            for (int k = 0; k < dwf(id)/8; k++)
               if (v.wstrb[k]) mdl[id][v.addr][8*k +: 8] = v.wdata[8*k +: 8];
         end else begin
            e.rv = 1'b1;
            e.rd = mdl[id][v.addr];
            if (cm[v.addr]) mdl[id][v.addr] = '0;
         end
      end
      rd_last[id] = e.rd;
      return e;
   endfunction

   function automatic row_t mk(logic r, logic s, logic w, logic [2:0] a, logic [31:0] d,
                               logic [3:0] st, logic rv, logic er, logic [31:0] rd);
      row_t x;
      x.v = '{rst: r, sel: s, wr: w, addr: a, wdata: d, wstrb: st};
      x.e = '{rv: rv, er: er, rd: rd};
      return x;
   endfunction

   task automatic apply(int id, vec_t v, bit use_tab, exp_t tab_e);
      exp_t e;
      @(negedge clk);
      case (id)
         0: begin
            rst_a = v.rst; if_a.sel = v.sel; if_a.wr = v.wr; if_a.addr = v.addr[1:0];
            if_a.wdata = v.wdata[15:0]; if_a.wstrb = v.wstrb[1:0];
         end
         1: begin
            rst_b = v.rst; if_b.sel = v.sel; if_b.wr = v.wr; if_b.addr = v.addr;
            if_b.wdata = v.wdata[15:0]; if_b.wstrb = v.wstrb[1:0];
         end
         default: begin
            rst_c = v.rst; if_c.sel = v.sel; if_c.wr = v.wr; if_c.addr = v.addr;
            if_c.wdata = v.wdata; if_c.wstrb = v.wstrb;
         end
      endcase
      e = mstep(id, v);
      if (use_tab) e = tab_e;
      case (id)
         0:       qa.push_back(e);
         1:       qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   task automatic check(int id, logic rv, logic er, logic [31:0] rd, logic [255:0] mf, exp_t e);
      logic [31:0] mask;
      logic [31:0] got;
      mask = (dwf(id) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      n_tests++;
      if (rv !== e.rv) begin
         n_fail++;
         $display("FAIL dut%0d rvalid: got %0b expected %0b at %0t", id, rv, e.rv, $time);
      end
      n_tests++;
      if (er !== e.er) begin
         n_fail++;
         $display("FAIL dut%0d err: got %0b expected %0b at %0t", id, er, e.er, $time);
      end
      n_tests++;
      if (rd !== e.rd) begin
         n_fail++;
         $display("FAIL dut%0d rdata: got %h expected %h at %0t", id, rd, e.rd, $time);
      end
      for (int i = 0; i < depthf(id); i++) begin
         got = mf[dwf(id)*i +: 32] & mask;
         n_tests++;
         if (got !== (mdl[id][i] & mask)) begin
            n_fail++;
            $display("FAIL dut%0d mem_flat[%0d]: got %h expected %h at %0t",
                     id, i, got, mdl[id][i] & mask, $time);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (qa.size() != 0) check(0, if_a.rvalid, if_a.err, 32'(if_a.rdata), 256'(if_a.mem_flat), qa.pop_front());
      if (qb.size() != 0) check(1, if_b.rvalid, if_b.err, 32'(if_b.rdata), 256'(if_b.mem_flat), qb.pop_front());
      if (qc.size() != 0) check(2, if_c.rvalid, if_c.err, if_c.rdata, 256'(if_c.mem_flat), qc.pop_front());
   end

   initial begin
      row_t tab_a[$];
      row_t tab_b[$];
      vec_t v;
      exp_t none;

      none = '0;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      if_a.sel = 1'b0; if_a.wr = 1'b0; if_a.addr = '0; if_a.wdata = '0; if_a.wstrb = '0;
      if_b.sel = 1'b0; if_b.wr = 1'b0; if_b.addr = '0; if_b.wdata = '0; if_b.wstrb = '0;
      if_c.sel = 1'b0; if_c.wr = 1'b0; if_c.addr = '0; if_c.wdata = '0; if_c.wstrb = '0;
      for (int i = 0; i < 3; i++) rd_last[i] = '0;

      //                rst sel wr addr wdata         strb  rv er rdata
      tab_a.push_back(mk(0, 0, 0, 3'd0, 32'h0,      4'h0, 0, 0, 32'h0));
      tab_a.push_back(mk(0, 1, 0, 3'd0, 32'h0,      4'h0, 0, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 0, 3'd0, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 0, 3'd1, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 0, 3'd2, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 0, 3'd3, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 1, 3'd2, 32'h1234,   4'h3, 0, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 1, 3'd2, 32'hFFCD,   4'h1, 0, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 0, 3'd2, 32'h0,      4'h0, 1, 0, 32'h12CD));
      tab_a.push_back(mk(1, 1, 0, 3'd0, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 0, 3'd3, 32'h0,      4'h0, 1, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 1, 3'd3, 32'hBEEF,   4'h3, 0, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 0, 3'd3, 32'hFFFF,   4'h3, 1, 0, 32'hBEEF));
      tab_a.push_back(mk(1, 1, 0, 3'd3, 32'h0,      4'h0, 1, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 1, 3'd1, 32'hFFFF,   4'h0, 0, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 0, 3'd1, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 1, 1, 3'd1, 32'h0F0F,   4'h3, 0, 0, 32'hA5A5));
      tab_a.push_back(mk(0, 1, 0, 3'd1, 32'h0,      4'h0, 0, 0, 32'h0));
      tab_a.push_back(mk(1, 1, 0, 3'd1, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_a.push_back(mk(1, 0, 1, 3'd2, 32'hFFFF,   4'h3, 0, 0, 32'hA5A5));

      tab_b.push_back(mk(0, 0, 0, 3'd0, 32'h0,      4'h0, 0, 0, 32'h0));
      tab_b.push_back(mk(1, 1, 1, 3'd6, 32'hDEAD,   4'h3, 0, 1, 32'h0));
      tab_b.push_back(mk(1, 1, 0, 3'd7, 32'h0,      4'h0, 1, 1, 32'h0));
      tab_b.push_back(mk(1, 1, 0, 3'd4, 32'h0,      4'h0, 1, 0, 32'hA5A5));
      tab_b.push_back(mk(1, 1, 1, 3'd4, 32'h1111,   4'h2, 0, 0, 32'hA5A5));
      tab_b.push_back(mk(1, 1, 0, 3'd4, 32'h0,      4'h0, 1, 0, 32'h11A5));
      tab_b.push_back(mk(1, 1, 0, 3'd5, 32'h0,      4'h0, 1, 1, 32'h0));
      tab_b.push_back(mk(1, 0, 0, 3'd0, 32'h0,      4'h0, 0, 0, 32'h0));

      foreach (tab_a[i]) apply(0, tab_a[i].v, 1'b1, tab_a[i].e);
      foreach (tab_b[i]) apply(1, tab_b[i].v, 1'b1, tab_b[i].e);

      v = '{rst: 1'b0, sel: 1'b0, wr: 1'b0, addr: 3'd0, wdata: 32'h0, wstrb: 4'h0};
      apply(2, v, 1'b0, none);
      for (int n = 0; n < 1000; n++) begin
         v.rst   = 1'b1;
         v.sel   = ($urandom_range(0, 3) != 0);
         v.wr    = $urandom_range(0, 1) == 1;
         v.addr  = 3'($urandom_range(0, 7));
         v.wdata = $urandom;
         v.wstrb = 4'($urandom_range(0, 15));
         apply(2, v, 1'b0, none);
      end
      v.sel = 1'b0;
      apply(2, v, 1'b0, none);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Parametrised control/status register bank: DEPTH words of DW bits behind a single select/write/address port, with byte-strobed writes, registered reads with a valid pulse, per-entry clear-on-read and address-range error reporting. It is the general-purpose successor of the team's fixed 4×16 register array. It sits between a bus-side decoder (which drives `sel`) and the datapath logic that consumes the register contents.

## Interface
- `DW`, 16: data width in bits; must be a multiple of 8.
- `DEPTH`, 4: number of entries; must be at least 2, and need not be a power of 2.
- `AW`, `$clog2(DEPTH)`: address width.
- `RST_VAL`, 0: DW-bit reset value loaded into every entry.
- `COR_MASK`, 0: DEPTH-bit mask; when bit i is 1, entry i clears to 0 when it is read.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `sel`  in  1  access request, valid in the current cycle.
- `wr`  in  1  1 = write, 0 = read; sampled only while `sel`=1.
- `addr`  in  AW  entry index.
- `wdata`  in  DW  write data.
- `wstrb`  in  DW/8  byte enables; bit k enables `wdata[8k+7:8k]`.
- `rdata`  out  DW  registered read data.
- `rvalid`  out  1  one-cycle pulse; `rdata` is valid while it is high.
- `err`  out  1  one-cycle pulse on an access with `addr` ≥ DEPTH.
- `mem_flat`  out  DW*DEPTH  live contents; entry i is at bits `[DW*i +: DW]`, driven combinationally from the state.

## Operation
- **Reset** (rst=0 at a clock edge):
  - Every entry is set to `RST_VAL`.
  - `rdata`=0, `rvalid`=0, `err`=0.
  - Reset has priority over any access in the same cycle; an access presented during reset is dropped with no response.
- **Idle** (`sel`=0): entries hold their values. `rvalid` and `err` go to 0. `rdata` holds its last value.
- **Write** (`sel`=1, `wr`=1, `addr`<DEPTH):
  - Byte k of entry `addr` is replaced by `wdata` byte k wherever `wstrb[k]`=1.
  - All other bytes and all other entries are unchanged.
  - `wstrb`=0 is a legal no-op write.
  - Writes produce no `rvalid`.
- **Read** (`sel`=1, `wr`=0, `addr`<DEPTH):
  - Next edge: `rdata` ← entry[`addr`], `rvalid` ← 1.
  - If `COR_MASK[addr]`=1, the entry is also set to 0 on that same edge. `rdata` carries the pre-clear value.
- **Out-of-range** (`addr` ≥ DEPTH; only possible when DEPTH is not a power of 2):
  - Next edge: `err` ← 1; no entry changes.
  - For a read, `rdata` ← 0 and `rvalid` ← 1, so the bus always completes.
  - For a write, `rvalid` stays 0.
- **Internal state:** no FSM beyond the output flops. Each cycle is an independent transaction.

## Timing
- **Write latency:** 1 clock. An entry written at edge N is visible on `mem_flat` after edge N, and to a read issued in cycle N+1.
- **Read latency:** 1 clock from the cycle `sel`&~`wr` is sampled to `rdata`/`rvalid`. Back-to-back reads are allowed every cycle, giving one `rvalid` per cycle.
- **Write immediately followed by a read of the same address:** the read returns the newly written value; no stale data.
- **Two consecutive reads of the same COR entry:** the first returns the stored value, the second returns 0.
- **`err`:** asserted in the same cycle as the corresponding `rvalid` would be; never asserted for an in-range access.
- **Reset mid-stream:** a read sampled in the cycle rst=0 yields no `rvalid`. The first access after reset sees `RST_VAL`.
- **Don't-care inputs:** `wdata` and `wstrb` are ignored for reads. `wr`, `addr`, `wdata` and `wstrb` are ignored when `sel`=0.

## Test plan
- Reset with DW=16, DEPTH=4, RST_VAL=16'hA5A5; read addresses 0..3 on back-to-back cycles → four consecutive `rvalid` pulses, each with `rdata`=A5A5; `err`=0 throughout.
- Write addr 2 = 16'h1234 with `wstrb`=11, then write addr 2 = 16'hFFCD with `wstrb`=01, then read addr 2 → `rdata`=16'h12CD one cycle after the read; other entries still read A5A5.
- COR_MASK=4'b1000: write addr 3 = 16'hBEEF, then read addr 3 twice back-to-back → `rdata`=BEEF then 0000; `mem_flat[63:48]`=0 after the first read.
- DEPTH=5 (AW=3): write addr 6 with 16'hDEAD → `err` pulse, no `rvalid`, `mem_flat` unchanged. Read addr 7 → `err`=1, `rvalid`=1, `rdata`=0.
- Write addr 1 = 16'h0F0F, then hold `sel`=1, `wr`=0, addr=1 and drop rst to 0 for one cycle → no `rvalid` in the reset cycle; the following read returns A5A5.
- DW=32, DEPTH=8, random mix of 1000 reads and writes with random strobes → `rdata` matches a reference model on every `rvalid`; `err` is never asserted.
